run_control_trace: RTL and testbench

Synthesisable run controller and fetch-trace capture block for the pipelined core. It sequences the core's reset and start inputs, counts execution cycles against a budget, and halts the run at that budget or on request. During a run it records fetched (PC, instruction) pairs into a parametrised trace buffer, which is read back over a simple read port. It sits beside Pipeline_Top, drives that module's rst and start, and taps its decode-stage PC and instruction.

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/run_control_trace_fifo.sv | 129 ++++++++++++
 rtl/run_control_trace.sv | 163 ++++++++++++++++
 tb/tb_run_control_trace.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller and its trace buffer.
// Contents: run FSM state encoding and the trace buffer full-behaviour codes.
package run_ctrl_pkg;

  // Run sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  // Trace buffer behaviour on a write while full
  localparam int WRAP_DROP      = 0;  // discard the new entry
  localparam int WRAP_OVERWRITE = 1;  // replace the oldest entry

endpackage

// File: rtl/run_control_trace_fifo.sv
// trace_fifo: circular trace buffer with explicit occupancy count, sticky
// overflow flag and a registered read port.
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   clr               synchronous clear of pointers, count and overflow
//   wr_en, wr_data    push request and entry
//   rd_en             pop request (ignored when empty)
//   rd_data, rd_valid popped entry, valid the cycle after an accepted pop
//   count, empty, full, overflow  occupancy and status
module trace_fifo
  import run_ctrl_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = WRAP_DROP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             rd_valid_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             full_s;
  logic             empty_s;
  logic             do_rd_s;
  logic             do_wr_s;
  logic             wrap_s;
  logic             drop_s;

  // Resolve which requested operations take effect this cycle
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
    do_rd_s = rd_en && !empty_s;
    do_wr_s = 1'b0;
    wrap_s  = 1'b0;
    drop_s  = 1'b0;
    if (wr_en) begin
      // A same-cycle pop frees a slot, so a full buffer still accepts the write
      if (!full_s || do_rd_s) begin
        do_wr_s = 1'b1;
      end else if (WRAP_MODE == WRAP_OVERWRITE) begin
        do_wr_s = 1'b1;
        wrap_s  = 1'b1;
      end else begin
        drop_s  = 1'b1;
      end
    end else begin
      do_wr_s = 1'b0;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (clr) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      // An overwrite consumes the oldest slot, so the read side moves too
      if (do_rd_s || wrap_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (do_wr_s && !do_rd_s && !wrap_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (do_rd_s && !do_wr_s) begin
        count_r <= count_r - CNT_W'(1);
      end
      if (wrap_s || drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage (no reset needed: contents are qualified by count)
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else begin
      rd_valid_r <= do_rd_s;
      if (do_rd_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign count    = count_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign overflow = overflow_r;

endmodule

// File: rtl/run_control_trace.sv
// run_control_trace: sequences core reset/start, counts RUN cycles against a
// budget, and captures decode-stage (PC, instruction) pairs into a trace buffer.
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   go, halt_req             start a run (IDLE/DONE only), end RUN
//   core_rst, core_start     registered controls to the core
//   pc_d, instr_d, valid_d   decode-stage tap
//   rd_en, rd_pc, rd_instr, rd_valid  trace read port
//   trace_count/empty/full, overflow  trace status
//   cycle_count, busy, done  run status
module run_control_trace
  import run_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int RST_CYCLES  = 3,
  parameter int START_DELAY = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int CNT_W       = 16,
  parameter int TRACE_DEPTH = 16,
  parameter int WRAP_MODE   = WRAP_DROP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic                         halt_req,
  output logic                         core_rst,
  output logic                         core_start,
  input  logic [XLEN-1:0]              pc_d,
  input  logic [ILEN-1:0]              instr_d,
  input  logic                         valid_d,
  input  logic                         rd_en,
  output logic [XLEN-1:0]              rd_pc,
  output logic [ILEN-1:0]              rd_instr,
  output logic                         rd_valid,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_empty,
  output logic                         trace_full,
  output logic                         overflow,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         busy,
  output logic                         done
);

  // Phase counter times both RESET and WAIT; 16 bits covers any sane setting
  localparam int PH_W      = 16;
  localparam int WAIT_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  run_state_e             state_r;
  run_state_e             state_nxt_s;
  logic [PH_W-1:0]        phase_r;
  logic [PH_W-1:0]        phase_nxt_s;
  logic [CNT_W-1:0]       cycle_count_r;
  logic                   go_ok_s;
  logic                   core_rst_r;
  logic                   core_start_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   trace_wr_s;
  logic [XLEN+ILEN-1:0]   rd_data_s;

  // Next-state logic for the run sequencer
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    go_ok_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_nxt_s = ST_RESET;
          phase_nxt_s = {PH_W{1'b0}};
          go_ok_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESET: begin
        if (phase_r == PH_W'(RST_CYCLES - 1)) begin
          phase_nxt_s = {PH_W{1'b0}};
          state_nxt_s = (START_DELAY == 0) ? ST_RUN : ST_WAIT;
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_WAIT: begin
        if (phase_r == PH_W'(WAIT_LAST)) begin
          phase_nxt_s = {PH_W{1'b0}};
          state_nxt_s = ST_RUN;
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_RUN: begin
        // Leave on the edge whose increment reaches the budget
        if (halt_req || (cycle_count_r >= CNT_W'(MAX_CYCLES - 1))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        phase_nxt_s = {PH_W{1'b0}};
      end
    endcase
  end

  // State, cycle counter and registered control outputs (decoded from next state
  // so each output lines up with the state it belongs to)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      phase_r       <= {PH_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
      core_rst_r    <= 1'b1;
      core_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      phase_r      <= phase_nxt_s;
      core_rst_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RESET);
      core_start_r <= (state_nxt_s == ST_RUN);
      busy_r       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r       <= (state_nxt_s == ST_DONE);
      if (go_ok_s) begin
        cycle_count_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_RUN) && (cycle_count_r < CNT_W'(MAX_CYCLES))) begin
        cycle_count_r <= cycle_count_r + CNT_W'(1);
      end
    end
  end

  assign trace_wr_s = (state_r == ST_RUN) && valid_d;

  trace_fifo #(
    .WIDTH     (XLEN + ILEN),
    .DEPTH     (TRACE_DEPTH),
    .WRAP_MODE (WRAP_MODE)
  ) u_trace (
    .clk      (clk),
    .rst      (rst),
    .clr      (go_ok_s),
    .wr_en    (trace_wr_s),
    .wr_data  ({pc_d, instr_d}),
    .rd_en    (rd_en),
    .rd_data  (rd_data_s),
    .rd_valid (rd_valid),
    .count    (trace_count),
    .empty    (trace_empty),
    .full     (trace_full),
    .overflow (overflow)
  );

  assign rd_pc       = rd_data_s[XLEN+ILEN-1:ILEN];
  assign rd_instr    = rd_data_s[ILEN-1:0];
  assign core_rst    = core_rst_r;
  assign core_start  = core_start_r;
  assign cycle_count = cycle_count_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_run_control_trace.sv
// Self-checking bench: two instances (drop and overwrite trace modes, depth 4)
// share all stimulus; a queue model predicts trace contents and popped data.
module tb_run_control_trace;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        go;
  logic        halt_req;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        rd_en;

  logic        core_rst_a, core_start_a, rd_valid_a, trace_empty_a, trace_full_a;
  logic        overflow_a, busy_a, done_a;
  logic [31:0] rd_pc_a, rd_instr_a;
  logic [2:0]  trace_count_a;
  logic [15:0] cycle_count_a;
  logic        core_rst_b, core_start_b, rd_valid_b, trace_empty_b, trace_full_b;
  logic        overflow_b, busy_b, done_b;
  logic [31:0] rd_pc_b, rd_instr_b;
  logic [2:0]  trace_count_b;
  logic [15:0] cycle_count_b;

  run_control_trace #(.TRACE_DEPTH(DEPTH), .WRAP_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .go(go), .halt_req(halt_req),
    .core_rst(core_rst_a), .core_start(core_start_a),
    .pc_d(pc_d), .instr_d(instr_d), .valid_d(valid_d), .rd_en(rd_en),
    .rd_pc(rd_pc_a), .rd_instr(rd_instr_a), .rd_valid(rd_valid_a),
    .trace_count(trace_count_a), .trace_empty(trace_empty_a), .trace_full(trace_full_a),
    .overflow(overflow_a), .cycle_count(cycle_count_a), .busy(busy_a), .done(done_a)
  );

  run_control_trace #(.TRACE_DEPTH(DEPTH), .WRAP_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .go(go), .halt_req(halt_req),
    .core_rst(core_rst_b), .core_start(core_start_b),
    .pc_d(pc_d), .instr_d(instr_d), .valid_d(valid_d), .rd_en(rd_en),
    .rd_pc(rd_pc_b), .rd_instr(rd_instr_b), .rd_valid(rd_valid_b),
    .trace_count(trace_count_b), .trace_empty(trace_empty_b), .trace_full(trace_full_b),
    .overflow(overflow_b), .cycle_count(cycle_count_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        go;
    logic        halt;
    logic        e_rst;
    logic        e_start;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cnt;
  } fsm_vec_t;

  fsm_vec_t    vecs [8];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          go_edge = 0;
  bit          model_run = 1'b0;
  logic [63:0] m_a [$];
  logic [63:0] m_b [$];
  logic [63:0] e_a [$];
  logic [63:0] e_b [$];
  bit          ovf_a = 1'b0;
  bit          ovf_b = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_wr(input logic v, input logic [31:0] pc);
    valid_d = v;
    pc_d    = pc;
    instr_d = 32'hA500_0000 ^ pc;
  endtask

  // One clock: update the model with the inputs about to be sampled, then
  // compare the read port against the scoreboard.
  task automatic tick();
    bit          pa;
    bit          pb;
    logic [63:0] wd;
    logic [63:0] junk;
    pa = 1'b0;
    pb = 1'b0;
    wd = {pc_d, instr_d};
    if (!rst) begin
      m_a.delete(); m_b.delete(); e_a.delete(); e_b.delete();
      ovf_a = 1'b0; ovf_b = 1'b0;
    end else begin
      pa = rd_en && (m_a.size() != 0);
      pb = rd_en && (m_b.size() != 0);
      if (pa) e_a.push_back(m_a.pop_front());
      if (pb) e_b.push_back(m_b.pop_front());
      if (model_run && valid_d) begin
        if (m_a.size() < DEPTH) m_a.push_back(wd);
        else ovf_a = 1'b1;
        if (m_b.size() < DEPTH) m_b.push_back(wd);
        else begin
          junk = m_b.pop_front();
          m_b.push_back(wd);
          ovf_b = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("rd_valid_drop", {63'd0, rd_valid_a}, {63'd0, pa});
    chk("rd_valid_ovwr", {63'd0, rd_valid_b}, {63'd0, pb});
    if (pa && rd_valid_a) chk("rd_data_drop", {rd_pc_a, rd_instr_a}, e_a.pop_front());
    if (pb && rd_valid_b) chk("rd_data_ovwr", {rd_pc_b, rd_instr_b}, e_b.pop_front());
  endtask

  task automatic do_go();
    go = 1'b1;
    tick();
    go = 1'b0;
    m_a.delete(); m_b.delete();
    ovf_a = 1'b0; ovf_b = 1'b0;
    go_edge = cyc;
  endtask

  task automatic chk_trace(input string tag);
    chk({tag, "_count_drop"}, 64'(trace_count_a), 64'(m_a.size()));
    chk({tag, "_count_ovwr"}, 64'(trace_count_b), 64'(m_b.size()));
    chk({tag, "_ovf_drop"}, 64'(overflow_a), 64'(ovf_a));
    chk({tag, "_ovf_ovwr"}, 64'(overflow_b), 64'(ovf_b));
  endtask

  initial begin
    int n;
    // {go, halt, core_rst, core_start, busy, done, cycle_count}, one row per
    // cycle after the go edge; the go/halt pulses land where they are ignored
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};

    rst = 1'b0; go = 1'b0; halt_req = 1'b0; rd_en = 1'b0;
    set_wr(1'b0, 32'h0);
    tick();
    tick();
    chk("rst_core_rst", 64'(core_rst_a), 64'd1);
    chk("rst_core_start", 64'(core_start_a), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_empty", 64'(trace_empty_a), 64'd1);
    chk("rst_rd_pc", 64'(rd_pc_a), 64'd0);
    chk_trace("rst");
    rst = 1'b1;
    while (cyc < 5) tick();

    // Basic run to the cycle budget
    do_go();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("seq%0d_core_rst", i), 64'(core_rst_a), 64'(vecs[i].e_rst));
      chk($sformatf("seq%0d_core_start", i), 64'(core_start_a), 64'(vecs[i].e_start));
      chk($sformatf("seq%0d_busy", i), 64'(busy_a), 64'(vecs[i].e_busy));
      chk($sformatf("seq%0d_done", i), 64'(done_a), 64'(vecs[i].e_done));
      chk($sformatf("seq%0d_count", i), 64'(cycle_count_a), 64'(vecs[i].e_cnt));
      go = vecs[i].go;
      halt_req = vecs[i].halt;
      tick();
      go = 1'b0;
      halt_req = 1'b0;
    end
    n = 0;
    while (!done_a && n < 300) begin
      tick();
      n++;
    end
    chk("budget_done_seen", 64'(done_a), 64'd1);
    chk("budget_done_edge", 64'(cyc - go_edge), 64'd105);
    chk("budget_count", 64'(cycle_count_a), 64'd100);
    chk("budget_core_start", 64'(core_start_a), 64'd0);
    chk("budget_core_rst", 64'(core_rst_a), 64'd0);
    chk("budget_busy", 64'(busy_a), 64'd0);
    halt_req = 1'b1;
    repeat (3) tick();
    halt_req = 1'b0;
    chk("done_frozen_count", 64'(cycle_count_a), 64'd100);
    chk("done_still_done", 64'(done_a), 64'd1);

    // Restart, trace six PCs past a depth-4 buffer, halt at RUN cycle 7
    do_go();
    chk("go2_count_clear", 64'(cycle_count_a), 64'd0);
    chk("go2_core_rst", 64'(core_rst_a), 64'd1);
    repeat (5) tick();
    model_run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_wr(1'b1, 32'(4 * k));
      tick();
    end
    set_wr(1'b0, 32'h0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    model_run = 1'b0;
    chk("halt_done", 64'(done_a), 64'd1);
    chk("halt_count", 64'(cycle_count_a), 64'd7);
    chk("halt_full_drop", 64'(trace_full_a), 64'd1);
    chk("halt_full_ovwr", 64'(trace_full_b), 64'd1);
    chk_trace("halt");
    rd_en = 1'b1;
    repeat (5) tick();
    rd_en = 1'b0;
    tick();
    chk("drained_empty_drop", 64'(trace_empty_a), 64'd1);
    chk("drained_empty_ovwr", 64'(trace_empty_b), 64'd1);

    // Go from DONE clears overflow; then read+write together at full
    do_go();
    chk_trace("go3");
    chk("go3_count_clear", 64'(cycle_count_a), 64'd0);
    repeat (5) tick();
    model_run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_wr(1'b1, 32'h100 + 32'(4 * k));
      tick();
    end
    set_wr(1'b1, 32'h200);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    set_wr(1'b0, 32'h0);
    chk_trace("simul");
    chk("simul_full_drop", 64'(trace_full_a), 64'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    model_run = 1'b0;
    chk("simul_halt_count", 64'(cycle_count_a), 64'd6);
    do_go();
    chk("go4_trace_clear_drop", 64'(trace_empty_a), 64'd1);
    chk("go4_trace_clear_ovwr", 64'(trace_empty_b), 64'd1);
    chk_trace("go4");

    // Reset in the middle of a run
    repeat (5) tick();
    model_run = 1'b1;
    set_wr(1'b1, 32'h300);
    tick();
    set_wr(1'b1, 32'h304);
    tick();
    chk_trace("midrun");
    set_wr(1'b0, 32'h0);
    model_run = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_core_rst", 64'(core_rst_a), 64'd1);
    chk("midrst_core_start", 64'(core_start_a), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);
    chk("midrst_done", 64'(done_a), 64'd0);
    chk("midrst_count", 64'(cycle_count_a), 64'd0);
    chk("midrst_empty_drop", 64'(trace_empty_a), 64'd1);
    chk("midrst_empty_ovwr", 64'(trace_empty_b), 64'd1);
    chk_trace("midrst");
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk("idle_core_rst", 64'(core_rst_a), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
